// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types for the core-side ibus/dbus and the merged memory-side channel.
// Also holds the arbiter FSM state encoding and the access size codes.
package core_bus_arbiter_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] MSIZE1 = 3'b000;
    localparam logic [2:0] MSIZE2 = 3'b001;
    localparam logic [2:0] MSIZE4 = 3'b010;
    localparam logic [2:0] MSIZE8 = 3'b011;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/core_bus_arbiter.sv
// Serialises the core's ibus and dbus onto one memory request channel, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed dbus priority.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mem_req_t   oreq,
    input  mem_resp_t  oresp
);

    arb_state_t state_q, state_d;
    mem_req_t   oreq_q, oreq_d;
    ibus_resp_t iresp_q, iresp_d;
    dbus_resp_t dresp_q, dresp_d;
    logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = ibus won the previous grant, 1 = dbus did
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_d = dreq.valid;
        if (dreq.valid && ireq.valid) begin
            grant_d = ~last_grant_q;
        end
    end
`else
    always_comb begin
        grant_d = dreq.valid;
    end
`endif

    // oreq_q doubles as the request latch; it is only re-loaded on a grant
    always_comb begin
        state_d         = state_q;
        oreq_d          = oreq_q;
        iresp_d         = '0;
        iresp_d.data    = iresp_q.data;
        dresp_d         = '0;
        dresp_d.data    = dresp_q.data;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d    = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dreq.valid || ireq.valid) begin
                    oreq_d.valid = 1'b1;
                    if (grant_d) begin
                        oreq_d.is_write = (dreq.strobe != '0);
                        oreq_d.size     = dreq.size;
                        oreq_d.addr     = dreq.addr;
                        oreq_d.strobe   = dreq.strobe;
                        oreq_d.data     = dreq.data;
                        dresp_d.addr_ok = 1'b1;
                        state_d         = DBUSY;
                    end else begin
                        oreq_d.is_write = 1'b0;
                        oreq_d.size     = MSIZE4;
                        oreq_d.addr     = ireq.addr;
                        oreq_d.strobe   = '0;
                        oreq_d.data     = '0;
                        iresp_d.addr_ok = 1'b1;
                        state_d         = IBUSY;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_d;
`endif
                end
            end
            IBUSY: begin
                if (oresp.ready) begin
                    oreq_d.valid    = 1'b0;
                    iresp_d.data_ok = 1'b1;
                    iresp_d.data    = oreq_q.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
                    state_d         = DONE;
                end
            end
            DBUSY: begin
                if (oresp.ready) begin
                    oreq_d.valid    = 1'b0;
                    dresp_d.data_ok = 1'b1;
                    dresp_d.data    = oresp.data;
                    state_d         = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            oreq_q  <= '0;
            iresp_q <= '0;
            dresp_q <= '0;
        end else begin
            state_q <= state_d;
            oreq_q  <= oreq_d;
            iresp_q <= iresp_d;
            dresp_q <= dresp_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign oreq  = oreq_q;
    assign iresp = iresp_q;
    assign dresp = dresp_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter: fetch, store, contention, stall, reset, grant order.
// Inputs are driven and outputs sampled on the falling edge.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_req_t   oreq;
    mem_resp_t  oresp;

    int checks   = 0;
    int failures = 0;

    core_bus_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // 'd' or 'i' for each of three contended grants
    byte exp_order [3];
    byte winner;
    bit  seen;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{8'h64, 8'h69, 8'h64};
`else
        exp_order = '{8'h64, 8'h64, 8'h64};
`endif
        rst   = 1'b0;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        repeat (3) step();
        chk("rst_oreq",  64'(oreq.valid),    64'd0);
        chk("rst_iresp", 64'(iresp.addr_ok | iresp.data_ok), 64'd0);
        chk("rst_dresp", 64'(dresp.addr_ok | dresp.data_ok), 64'd0);
        chk("rst_odata", oreq.addr, 64'd0);
        rst = 1'b1;
        step();

        // fetch, upper word selected by addr[2]
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        step();
        chk("f_addr_ok",  64'(iresp.addr_ok), 64'd1);
        chk("f_valid",    64'(oreq.valid),    64'd1);
        chk("f_size",     64'(oreq.size),     64'd2);
        chk("f_wr",       64'(oreq.is_write), 64'd0);
        chk("f_addr",     oreq.addr,          64'h8000_0004);
        chk("f_d_ok",     64'(dresp.addr_ok), 64'd0);
        step();
        chk("f_addr_ok2", 64'(iresp.addr_ok), 64'd0);
        chk("f_valid2",   64'(oreq.valid),    64'd1);
        oresp.ready = 1'b1;
        oresp.data  = 64'hDEAD_BEEF_1234_5678;
        step();
        oresp.ready = 1'b0;
        chk("f_data_ok",  64'(iresp.data_ok), 64'd1);
        chk("f_data",     64'(iresp.data),    64'hDEAD_BEEF);
        chk("f_valid3",   64'(oreq.valid),    64'd0);
        ireq = '0;
        step();
        chk("f_data_ok2", 64'(iresp.data_ok), 64'd0);
        step();

        // store, ready in the first busy cycle
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_1000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h1122_3344_5566_7788;
        step();
        chk("s_addr_ok",  64'(dresp.addr_ok), 64'd1);
        chk("s_wr",       64'(oreq.is_write), 64'd1);
        chk("s_strobe",   64'(oreq.strobe),   64'hFF);
        chk("s_data",     oreq.data,          64'h1122_3344_5566_7788);
        chk("s_size",     64'(oreq.size),     64'd3);
        oresp.ready = 1'b1;
        oresp.data  = 64'h0;
        step();
        oresp.ready = 1'b0;
        chk("s_data_ok",  64'(dresp.data_ok), 64'd1);
        chk("s_valid",    64'(oreq.valid),    64'd0);
        dreq = '0;
        step();
        chk("s_data_ok2", 64'(dresp.data_ok), 64'd0);
        step();

        // contention: dbus first, ibus served after DONE
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8000_0010;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_2000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
`ifndef ARB_ROUND_ROBIN_EN
        step();
        chk("c_d_addr_ok", 64'(dresp.addr_ok), 64'd1);
        chk("c_i_addr_ok", 64'(iresp.addr_ok), 64'd0);
        chk("c_addr",      oreq.addr,          64'h8000_2000);
        chk("c_wr",        64'(oreq.is_write), 64'd0);
        oresp.ready = 1'b1;
        oresp.data  = 64'hCAFE_F00D_0BAD_F00D;
        step();
        oresp.ready = 1'b0;
        chk("c_d_data_ok", 64'(dresp.data_ok), 64'd1);
        chk("c_d_data",    dresp.data,         64'hCAFE_F00D_0BAD_F00D);
        chk("c_i_data_ok", 64'(iresp.data_ok), 64'd0);
        dreq = '0;
        step();
        chk("c_idle_i",    64'(iresp.addr_ok), 64'd0);
        chk("c_idle_v",    64'(oreq.valid),    64'd0);
        step();
        chk("c_i_grant",   64'(iresp.addr_ok), 64'd1);
        chk("c_i_addr",    oreq.addr,          64'h8000_0010);
        oresp.ready = 1'b1;
        step();
        oresp.ready = 1'b0;
        chk("c_i_done",    64'(iresp.data_ok), 64'd1);
        chk("c_i_lo",      64'(iresp.data),    64'h0BAD_F00D);
        ireq = '0;
        dreq = '0;
        step();
        step();
`endif

        // ready held off for 10 cycles
        ireq        = '0;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_3008;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        chk("h_addr_ok", 64'(dresp.addr_ok), 64'd1);
        dreq.addr = 64'h0;
        dreq.data = 64'h0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("h_addr_ok0", 64'(dresp.addr_ok), 64'd0);
            chk("h_valid",    64'(oreq.valid),    64'd1);
            chk("h_addr",     oreq.addr,          64'h8000_3008);
            chk("h_data",     oreq.data,          64'hAAAA_BBBB_CCCC_DDDD);
            chk("h_data_ok0", 64'(dresp.data_ok), 64'd0);
        end
        oresp.ready = 1'b1;
        oresp.data  = 64'h0123_4567_89AB_CDEF;
        step();
        oresp.ready = 1'b0;
        chk("h_data_ok", 64'(dresp.data_ok), 64'd1);
        chk("h_rdata",   dresp.data,         64'h0123_4567_89AB_CDEF);
        dreq = '0;
        step();
        chk("h_data_ok2", 64'(dresp.data_ok), 64'd0);
        step();

        // reset during DBUSY, then a stray ready
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_4000;
        dreq.strobe = 8'h01;
        step();
        chk("r_busy", 64'(oreq.valid), 64'd1);
        rst = 1'b0;
        step();
        chk("r_valid",  64'(oreq.valid),     64'd0);
        chk("r_dresp",  64'(dresp.addr_ok | dresp.data_ok), 64'd0);
        chk("r_iresp",  64'(iresp.addr_ok | iresp.data_ok), 64'd0);
        rst  = 1'b1;
        dreq = '0;
        oresp.ready = 1'b1;
        step();
        oresp.ready = 1'b0;
        chk("r_stray", 64'(dresp.data_ok), 64'd0);
        step();
        chk("r_stray2", 64'(dresp.data_ok | iresp.data_ok | oreq.valid), 64'd0);

        // back-to-back contended pairs, grant order
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8000_5000;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_6000;
        dreq.strobe = 8'h00;
        for (int g = 0; g < 3; g++) begin
            seen   = 1'b0;
            winner = 8'h3F;
            for (int w = 0; w < 8 && !seen; w++) begin
                step();
                if (dresp.addr_ok) begin winner = 8'h64; seen = 1'b1; end
                else if (iresp.addr_ok) begin winner = 8'h69; seen = 1'b1; end
            end
            chk("o_grant_seen", 64'(seen), 64'd1);
            chk("o_order", 64'(winner), 64'(exp_order[g]));
            oresp.ready = 1'b1;
            step();
            oresp.ready = 1'b0;
        end
        ireq = '0;
        dreq = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
